// File: rtl/sand_pkg.sv
// Shared cell encodings, FSM state type and sizing helper for the sand update engine.
// The diagonal test states exist only when SAND_DIAGONAL_EN is defined.
package sand_pkg;

  localparam int unsigned CELL_WIDTH = 8;
  typedef logic [CELL_WIDTH-1:0] cell_t;

  localparam cell_t CELL_EMPTY = '0;
  localparam cell_t CELL_SAND  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_TEST_C,
    S_TEST_B,
    S_WR_DST,
    S_WR_SRC
`ifdef SAND_DIAGONAL_EN
    ,
    S_TEST_D1,
    S_TEST_D2
`endif
  } sand_state_t;

  function automatic int unsigned bits_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sand_scan_counter.sv
// Pixel scan counters: x/y position plus a linear address kept in step without a multiplier.
// Scan runs bottom row first, left to right; provides below / below-left / below-right addresses.
module sand_scan_counter
  import sand_pkg::*;
#(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned ADDR_WIDTH = 19
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic                  i_step,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [ADDR_WIDTH-1:0] o_addr_below,
  output logic [ADDR_WIDTH-1:0] o_addr_below_left,
  output logic [ADDR_WIDTH-1:0] o_addr_below_right,
  output logic                  o_last,
  output logic                  o_bottom_row,
  output logic                  o_left_edge,
  output logic                  o_right_edge
);

  localparam int unsigned XW = bits_for(WIDTH);
  localparam int unsigned YW = bits_for(HEIGHT);

  localparam logic [XW-1:0]         LP_X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0]         LP_Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_START    = ADDR_WIDTH'((HEIGHT - 1) * WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LP_ROW      = ADDR_WIDTH'(WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LP_ROW_M1   = ADDR_WIDTH'(WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_ROW_P1   = ADDR_WIDTH'(WIDTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LP_ROW_BACK = ADDR_WIDTH'(2 * WIDTH - 1);

  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [ADDR_WIDTH-1:0] r_addr;

  // End of row jumps from (W-1, y) to (0, y-1): address drops by 2W-1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (i_load) begin
      r_x    <= '0;
      r_y    <= LP_Y_LAST;
      r_addr <= LP_START;
    end else if (i_step) begin
      if (r_x == LP_X_LAST) begin
        r_x    <= '0;
        r_y    <= r_y - YW'(1);
        r_addr <= r_addr - LP_ROW_BACK;
      end else begin
        r_x    <= r_x + XW'(1);
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end
    end
  end

  assign o_addr             = r_addr;
  assign o_addr_below       = r_addr + LP_ROW;
  assign o_addr_below_left  = r_addr + LP_ROW_M1;
  assign o_addr_below_right = r_addr + LP_ROW_P1;
  assign o_left_edge        = (r_x == '0);
  assign o_right_edge       = (r_x == LP_X_LAST);
  assign o_bottom_row       = (r_y == LP_Y_LAST);
  assign o_last             = o_right_edge && (r_y == '0);

endmodule

// File: rtl/sand_update_engine.sv
// Per-frame falling-sand update: scans the framebuffer bottom-up and moves each grain one step.
// Define SAND_DIAGONAL_EN to let blocked grains slide diagonally (alternating left/right preference).
module sand_update_engine
  import sand_pkg::*;
#(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rd_address_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_address_o,
  output logic [DATA_WIDTH-1:0] wr_data_o
);

  localparam logic [DATA_WIDTH-1:0] LP_EMPTY = {DATA_WIDTH{CELL_EMPTY[0]}};
  localparam logic [DATA_WIDTH-1:0] LP_SAND  = {DATA_WIDTH{CELL_SAND[0]}};

  sand_state_t           r_state;
  sand_state_t           w_next;
  logic                  w_load;
  logic                  w_step;
  logic                  w_adv;
  logic                  w_done_set;
  logic                  w_dst_we;
  logic [ADDR_WIDTH-1:0] w_dst_d;
  logic [ADDR_WIDTH-1:0] r_dst_addr;
  logic                  r_done;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_addr_b;
  logic [ADDR_WIDTH-1:0] w_addr_bl;
  logic [ADDR_WIDTH-1:0] w_addr_br;
  logic                  w_last;
  logic                  w_bottom;
  logic                  w_left_edge;
  logic                  w_right_edge;
  logic                  w_cell_sand;
  logic                  w_cell_empty;

  assign w_cell_sand  = (rd_data_i == LP_SAND);
  assign w_cell_empty = (rd_data_i == LP_EMPTY);

  sand_scan_counter #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scan_counter (
    .i_clk              (clk_i),
    .i_rst_n            (rst_ni),
    .i_load             (w_load),
    .i_step             (w_step),
    .o_addr             (w_addr),
    .o_addr_below       (w_addr_b),
    .o_addr_below_left  (w_addr_bl),
    .o_addr_below_right (w_addr_br),
    .o_last             (w_last),
    .o_bottom_row       (w_bottom),
    .o_left_edge        (w_left_edge),
    .o_right_edge       (w_right_edge)
  );

`ifdef SAND_DIAGONAL_EN
  logic                  r_dir;
  logic                  r_d1_right;
  logic                  r_d2_ok;
  logic                  w_diag_we;
  logic                  w_d1_right_d;
  logic                  w_d2_ok_d;
  logic                  w_first_ok;
  logic                  w_second_ok;
  logic                  w_d1_look;
  logic [ADDR_WIDTH-1:0] w_d1_addr;
  logic [ADDR_WIDTH-1:0] w_d2_addr;

  // r_dir = 1 means right is tried first; an edge-skipped first choice falls back to the other side.
  assign w_first_ok  = r_dir ? !w_right_edge : !w_left_edge;
  assign w_second_ok = r_dir ? !w_left_edge  : !w_right_edge;
  assign w_d1_look   = w_first_ok ? r_dir : !r_dir;
  assign w_d1_addr   = r_d1_right ? w_addr_br : w_addr_bl;
  assign w_d2_addr   = r_d1_right ? w_addr_bl : w_addr_br;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dir      <= 1'b0;
      r_d1_right <= 1'b0;
      r_d2_ok    <= 1'b0;
    end else if (w_diag_we) begin
      r_dir      <= !r_dir;
      r_d1_right <= w_d1_right_d;
      r_d2_ok    <= w_d2_ok_d;
    end
  end
`else
  logic w_unused_diag;
  assign w_unused_diag = ^{w_addr_bl, w_addr_br, w_left_edge, w_right_edge};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done     <= 1'b0;
      r_dst_addr <= '0;
    end else begin
      r_done <= w_done_set;
      if (w_dst_we) begin
        r_dst_addr <= w_dst_d;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_adv      = 1'b0;
    w_done_set = 1'b0;
    w_dst_we   = 1'b0;
    w_dst_d    = w_addr_b;
`ifdef SAND_DIAGONAL_EN
    w_diag_we    = 1'b0;
    w_d1_right_d = r_d1_right;
    w_d2_ok_d    = r_d2_ok;
`endif
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_load = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_FETCH: w_next = S_TEST_C;
      S_TEST_C: begin
        if (!w_cell_sand || w_bottom) begin
          w_adv = 1'b1;
        end else begin
          w_next = S_TEST_B;
        end
      end
      S_TEST_B: begin
        if (w_cell_empty) begin
          w_dst_we = 1'b1;
          w_dst_d  = w_addr_b;
          w_next   = S_WR_DST;
        end
`ifdef SAND_DIAGONAL_EN
        else if (w_first_ok || w_second_ok) begin
          w_diag_we    = 1'b1;
          w_d1_right_d = w_d1_look;
          w_d2_ok_d    = w_first_ok && w_second_ok;
          w_next       = S_TEST_D1;
        end
`endif
        else begin
          w_adv = 1'b1;
        end
      end
`ifdef SAND_DIAGONAL_EN
      S_TEST_D1: begin
        if (w_cell_empty) begin
          w_dst_we = 1'b1;
          w_dst_d  = w_d1_addr;
          w_next   = S_WR_DST;
        end else if (r_d2_ok) begin
          w_next = S_TEST_D2;
        end else begin
          w_adv = 1'b1;
        end
      end
      S_TEST_D2: begin
        if (w_cell_empty) begin
          w_dst_we = 1'b1;
          w_dst_d  = w_d2_addr;
          w_next   = S_WR_DST;
        end else begin
          w_adv = 1'b1;
        end
      end
`endif
      S_WR_DST: w_next = S_WR_SRC;
      S_WR_SRC: w_adv  = 1'b1;
      default:  w_next = S_IDLE;
    endcase

    if (w_adv) begin
      if (w_last) begin
        w_done_set = 1'b1;
        w_next     = S_IDLE;
      end else begin
        w_step = 1'b1;
        w_next = S_FETCH;
      end
    end
  end

  // Each test state issues the read whose data the following state examines.
  always_comb begin
    busy_o       = (r_state != S_IDLE);
    done_o       = r_done;
    rd_address_o = '0;
    wr_en_o      = 1'b0;
    wr_address_o = '0;
    wr_data_o    = LP_EMPTY;
    case (r_state)
      S_FETCH:  rd_address_o = w_addr;
      S_TEST_C: rd_address_o = w_addr_b;
`ifdef SAND_DIAGONAL_EN
      S_TEST_B:  rd_address_o = w_d1_look ? w_addr_br : w_addr_bl;
      S_TEST_D1: rd_address_o = w_d2_addr;
`endif
      S_WR_DST: begin
        wr_en_o      = 1'b1;
        wr_address_o = r_dst_addr;
        wr_data_o    = LP_SAND;
      end
      S_WR_SRC: begin
        wr_en_o      = 1'b1;
        wr_address_o = w_addr;
        wr_data_o    = LP_EMPTY;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/sand_update_engine.md
# sand_update_engine

Per-frame physics stage for the falling-sand game, directly upstream of the framebuffer register file. On each `start_i` pulse it scans the whole WIDTH×HEIGHT framebuffer through the register file's single read port and single write port, moving each sand cell one step down or diagonally down. The framebuffer is therefore only ever written by this block during a scan.

## Interface
- `WIDTH`, 640, pixels per row
- `HEIGHT`, 480, rows
- `ADDR_WIDTH`, 19, framebuffer address width; must hold WIDTH*HEIGHT-1
- `DATA_WIDTH`, 8, cell width
- `clk_i`  in  1  system clock; all logic on the rising edge
- `rst_ni`  in  1  reset, asynchronous and active-low
- `start_i`  in  1  one-cycle frame tick; starts a scan when idle
- `busy_o`  out  1  high from the cycle after an accepted start until `done_o`
- `done_o`  out  1  one-cycle pulse after the last pixel is processed
- `rd_address_o`  out  ADDR_WIDTH  framebuffer read address
- `rd_data_i`  in  DATA_WIDTH  framebuffer read data; valid one cycle after the address
- `wr_en_o`  out  1  framebuffer write enable
- `wr_address_o`  out  ADDR_WIDTH  framebuffer write address
- `wr_data_o`  out  DATA_WIDTH  framebuffer write data

## Operation
- Cell encoding: `CELL_EMPTY` = 0 and `CELL_SAND` = all ones. Any other value is a static obstacle and never moves.
- Scan order:
  - rows from y = HEIGHT-1 up to y = 0; within each row, x = 0 to WIDTH-1.
  - address = y*WIDTH + x, maintained incrementally with no multiplier.
- States:
  - `IDLE`: on `start_i` go to `FETCH` at x = 0, y = HEIGHT-1.
  - `FETCH`: drive the current address, then go to `TEST_C`.
  - `TEST_C`: if the cell is not sand, or y = HEIGHT-1, advance. Otherwise drive the address below and go to `TEST_B`.
  - `TEST_B`: if the cell below is empty, the destination is below; go to `WR_DST`. Otherwise try the diagonals (configurable); if none is possible, advance.
  - `TEST_D1` / `TEST_D2`: test the first-preference and second-preference diagonal cells.
  - `WR_DST`: write `CELL_SAND` to the destination.
  - `WR_SRC`: write `CELL_EMPTY` to the source, then advance.
- Advance means the next pixel goes to `FETCH`. After x = WIDTH-1, y = 0, the block pulses `done_o` and returns to `IDLE`.
- Diagonal preference:
  - a direction bit, reset 0, where 0 means left first.
  - it toggles on every entry to `TEST_D1`.
  - at x = 0 the left neighbour is skipped; at x = WIDTH-1 the right neighbour is skipped.
- Moved sand always lands in a row that has already been scanned, so it moves at most one cell per frame.
- `start_i` while busy is ignored.
- `wr_en_o` is high only in `WR_DST` and `WR_SRC`.

## Timing
- Reset values:
  - state `IDLE`, direction bit 0
  - `busy_o`, `done_o`, `wr_en_o` = 0
  - `rd_address_o`, `wr_address_o`, `wr_data_o` = 0
- Cycles per pixel:
  - non-sand pixel or bottom row: 2
  - vertical fall: 5
  - diagonal move: 6 or 7
  - blocked sand: 3 to 5
- Minimum frame length is 2*WIDTH*HEIGHT + 1 cycles (614401 at the default size). The frame tick period must exceed the worst case, or ticks are dropped.
- No read ever targets an address written in the immediately preceding cycle, so no read-during-write hazard occurs.
- `done_o` is asserted in the same cycle `busy_o` falls.
- Reset mid-scan: return to `IDLE` immediately with writes deasserted. The framebuffer may be left partially updated, which is acceptable.

## Configuration
- `SAND_DIAGONAL_EN` defined: diagonal states are compiled in, and blocked sand slides diagonally as described.
- `SAND_DIAGONAL_EN` undefined:
  - `TEST_D1`, `TEST_D2` and the direction bit are absent.
  - sand only falls vertically; a blocked cell costs 3 cycles.

## Structure
- `sand_pkg` holds the cell constants `CELL_EMPTY` and `CELL_SAND` and the state enum `sand_state_t`.
- One sub-module, `sand_scan_counter`, holds the x/y/address counters. It has load-start, step, and last-pixel flag functions, and provides the below/left/right address offsets.

## Test plan
- Empty 4×3 framebuffer, start → no writes; `done_o` exactly 25 cycles after start.
- Single sand at (1,0) in a 4×3 frame → after frame 1, (1,1) = FF and (1,0) = 00; after frame 2, (1,2) = FF; frame 3 makes no writes.
- Sand at (1,1) with sand at (1,2), diagonals enabled → first frame moves it to (0,2); a second grain in the same situation moves to (2,2).
- Sand at (0,1) above an obstacle 0x01 at (0,2), with (1,2) sand → the cell does not move and no writes occur.
- Assert `start_i` while `busy_o` is high → ignored, and the frame length is unchanged.
- Drop `rst_ni` mid-scan → `wr_en_o` = 0 and `busy_o` = 0 immediately; the next start scans from (0,HEIGHT-1).
